// File: rtl/bin_to_bcd_blanker_if.sv
// Handshake and result bundle between a requester and the binary-to-BCD blanker.
// The master side drives start/bin; the slave (converter) returns status and display data.
interface bin_to_bcd_blanker_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, ovf, bcd, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, bcd, blank
    );
endinterface

// File: rtl/bin_to_bcd_blanker.sv
// Sequential double-dabble converter: one shift-add-3 step per clock.
// Produces registered packed BCD and a leading-zero blank mask for the display decoder.
module bin_to_bcd_blanker #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bin_to_bcd_blanker_if.slave    bus
);

    function automatic logic [63:0] max_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam int                  CNT_W     = $clog2(BIN_W + 1);
    localparam logic [63:0]         MAX_VAL   = max_value(DIGITS);
    localparam logic [DIGITS-1:0]   BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [BIN_W-1:0]       shreg;
    logic [4*DIGITS-1:0]    acc;
    logic [4*DIGITS-1:0]    acc_next;
    logic [CNT_W-1:0]       count;
    logic                   ovf_pend;
    logic                   cap_ovf;
    logic                   done_r;
    logic                   ovf_r;
    logic [4*DIGITS-1:0]    bcd_r;
    logic [DIGITS-1:0]      blank_r;
    logic [DIGITS-1:0]      blank_calc;

    assign cap_ovf = 64'(bus.bin) > MAX_VAL;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CONV;
            CONV:    if (count == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step; the top nibble's carry is dropped because it can
    // only occur for inputs already flagged as overflow at capture time.
    always_comb begin
        logic [3:0] adj;
        acc_next    = '0;
        adj         = '0;
        acc_next[0] = shreg[BIN_W-1];
        for (int d = 0; d < DIGITS; d++) begin
            adj = acc[4*d +: 4];
            if (adj >= 4'd5) adj = adj + 4'd3;
            acc_next[4*d+1 +: 3] = adj[2:0];
            if (d < DIGITS - 1) acc_next[4*d+4] = adj[3];
        end
    end

    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_calc = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            upper_zero    = upper_zero && (acc[4*d +: 4] == 4'd0);
            blank_calc[d] = upper_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            acc      <= '0;
            count    <= '0;
            ovf_pend <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            bcd_r    <= '0;
            blank_r  <= BLANK_RST;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg    <= bus.bin;
                        acc      <= '0;
                        count    <= CNT_W'(BIN_W);
                        ovf_pend <= cap_ovf;
                    end
                end
                CONV: begin
                    acc   <= acc_next;
                    shreg <= {shreg[BIN_W-2:0], 1'b0};
                    count <= count - CNT_W'(1);
                end
                FINISH: begin
                    done_r <= 1'b1;
                    ovf_r  <= ovf_pend;
                    if (ovf_pend) begin
                        bcd_r   <= {DIGITS{4'hE}};
                        blank_r <= '0;
                    end else begin
                        bcd_r   <= acc;
                        blank_r <= blank_calc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_r;
    assign bus.ovf   = ovf_r;
    assign bus.bcd   = bcd_r;
    assign bus.blank = blank_r;

endmodule

// File: tb/tb_bin_to_bcd_blanker.sv
// Bench for bin_to_bcd_blanker: directed corner cases plus randomized values
// compared against an arithmetic decimal-digit model.
module tb_bin_to_bcd_blanker;

    localparam int BIN_W  = 27;
    localparam int DIGITS = 8;
    localparam int LAT    = BIN_W + 1;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bin_to_bcd_blanker_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_blanker #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic bit model_ovf(input longint unsigned v);
        return v > 64'd99999999;
    endfunction

    function automatic logic [31:0] model_bcd(input longint unsigned v);
        logic [31:0] r;
        longint unsigned x;
        if (model_ovf(v)) return 32'hEEEE_EEEE;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] model_blank(input longint unsigned v);
        logic [7:0] b;
        longint unsigned p;
        if (model_ovf(v)) return 8'h00;
        b = 8'h00;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulses start at the current negedge and waits (bounded) for done.
    task automatic applyStimulus(input logic [BIN_W-1:0] v, input bit scramble, output int lat);
        bus.start = 1'b1;
        bus.bin   = v;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
        while (!bus.done && lat < LAT + 10) begin
            @(negedge clk);
            lat++;
            if (scramble) bus.bin = BIN_W'($urandom);
        end
    endtask

    task automatic checkResult(input string tag, input longint unsigned v, input int lat);
        checkOutput({tag, ".done"},    32'(bus.done),  32'd1);
        checkOutput({tag, ".latency"}, 32'(lat - 1),   32'(LAT));
        checkOutput({tag, ".bcd"},     bus.bcd,        model_bcd(v));
        checkOutput({tag, ".blank"},   32'(bus.blank), 32'(model_blank(v)));
        checkOutput({tag, ".ovf"},     32'(bus.ovf),   32'(model_ovf(v)));
    endtask

    task automatic checkDoneDrop(input string tag);
        @(negedge clk);
        checkOutput({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, ".busy_idle"},  32'(bus.busy), 32'd0);
    endtask

    initial begin
        int lat;
        bit saw_done;
        logic [BIN_W-1:0] v;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst.busy",  32'(bus.busy),  32'd0);
        checkOutput("rst.done",  32'(bus.done),  32'd0);
        checkOutput("rst.ovf",   32'(bus.ovf),   32'd0);
        checkOutput("rst.bcd",   bus.bcd,        32'h0);
        checkOutput("rst.blank", 32'(bus.blank), 32'hFE);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(27'd12345, 1'b1, lat);
        checkResult("v12345", 12345, lat);
        checkOutput("v12345.bcd_const", bus.bcd, 32'h0001_2345);
        checkOutput("v12345.blank_const", 32'(bus.blank), 32'hE0);
        checkDoneDrop("v12345");

        applyStimulus(27'd0, 1'b0, lat);
        checkResult("v0", 0, lat);
        checkOutput("v0.blank_const", 32'(bus.blank), 32'hFE);
        applyStimulus(27'd99999999, 1'b0, lat);
        checkResult("vmax", 99999999, lat);
        checkOutput("vmax.bcd_const", bus.bcd, 32'h9999_9999);

        applyStimulus(27'd100000000, 1'b0, lat);
        checkResult("vovf", 100000000, lat);
        checkOutput("vovf.bcd_const", bus.bcd, 32'hEEEE_EEEE);
        checkDoneDrop("vovf");
        applyStimulus(27'd7, 1'b0, lat);
        checkResult("v7", 7, lat);
        checkOutput("v7.ovf_clear", 32'(bus.ovf), 32'd0);

        bus.start = 1'b1;
        bus.bin   = 27'd500;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ignore.busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        bus.bin   = 27'd42;
        @(negedge clk);
        lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < LAT + 10) begin
            @(negedge clk);
            lat++;
        end
        checkResult("ignore500", 500, lat);
        checkOutput("ignore500.bcd_const", bus.bcd, 32'h500);
        applyStimulus(27'd42, 1'b0, lat);
        checkResult("ondone42", 42, lat);
        checkOutput("ondone42.bcd_const", bus.bcd, 32'h42);
        checkDoneDrop("ondone42");

        bus.start = 1'b1;
        bus.bin   = 27'd654321;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort.busy",  32'(bus.busy),  32'd0);
        checkOutput("abort.done",  32'(bus.done),  32'd0);
        checkOutput("abort.ovf",   32'(bus.ovf),   32'd0);
        checkOutput("abort.bcd",   bus.bcd,        32'h0);
        checkOutput("abort.blank", 32'(bus.blank), 32'hFE);
        saw_done = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        checkOutput("abort.no_done", 32'(saw_done), 32'd0);
        applyStimulus(27'd654321, 1'b0, lat);
        checkResult("restart", 654321, lat);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0:       v = BIN_W'($urandom_range(0, 999));
                1:       v = BIN_W'($urandom_range(0, 99999999));
                default: v = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
            endcase
            applyStimulus(v, 1'b1, lat);
            checkResult($sformatf("rand%0d_%0d", n, v), longint'(v), lat);
            if (n % 6 == 0) checkDoneDrop($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
